// File: rtl/thor2022_insn_gather.sv
// Thor2022 instruction gather: bundles EXI/EXIM prefixes with their base instruction into one decode packet.
// Optional EXIM (M-prefix) support is enabled by defining THOR2022_EXIM_EN.
module thor2022_insn_gather #(
    parameter int IW = 64,
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [IW-1:0] in_ir_i,
    input  logic [AW-1:0] in_pc_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [IW-1:0] ir_o,
    output logic [IW-1:0] xir_o,
    output logic          xval_o,
    output logic [IW-1:0] mir_o,
    output logic          mval_o,
    output logic [AW-1:0] pc_o,
    output logic          grp_open_o,
    output logic          pfx_err_o
);

    localparam logic [7:0] EXI8  = 8'h46;
    localparam logic [7:0] EXI24 = 8'h48;
    localparam logic [7:0] EXI40 = 8'h4A;
    localparam logic [7:0] EXI56 = 8'h4C;
`ifdef THOR2022_EXIM_EN
    localparam logic [7:0] EXIM  = 8'h50;

    typedef enum logic [1:0] {IDLE, GX, GM, GXM} state_t;
`else
    typedef enum logic [0:0] {IDLE, GX} state_t;
`endif

    state_t        state_reg, state_next;
    logic [IW-1:0] xhold_reg, xhold_next;
    logic [AW-1:0] pc_hold_reg, pc_hold_next;
    logic          out_valid_reg, out_valid_next;
    logic [IW-1:0] ir_reg, ir_next;
    logic [IW-1:0] xir_reg, xir_next;
    logic          xval_reg, xval_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic          pfx_err_reg, pfx_err_next;
`ifdef THOR2022_EXIM_EN
    logic [IW-1:0] mhold_reg, mhold_next;
    logic [IW-1:0] mir_reg, mir_next;
    logic          mval_reg, mval_next;
`endif

    logic [7:0] opcode;
    logic       is_x;
    logic       is_m;
    logic       x_held;
    logic       m_held;
    logic       accept;

    assign opcode = in_ir_i[7:0];
    assign is_x   = (opcode == EXI8)  || (opcode == EXI8  + 8'd1) ||
                    (opcode == EXI24) || (opcode == EXI24 + 8'd1) ||
                    (opcode == EXI40) || (opcode == EXI40 + 8'd1) ||
                    (opcode == EXI56) || (opcode == EXI56 + 8'd1);
`ifdef THOR2022_EXIM_EN
    assign is_m   = (opcode == EXIM);
    assign x_held = (state_reg == GX) || (state_reg == GXM);
    assign m_held = (state_reg == GM) || (state_reg == GXM);
`else
    assign is_m   = 1'b0;
    assign x_held = (state_reg == GX);
    assign m_held = 1'b0;
`endif

    // Prefixes are gated by the same ready as base words so a stall never splits a group.
    assign in_ready_o = !out_valid_reg || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        state_next     = state_reg;
        xhold_next     = xhold_reg;
        pc_hold_next   = pc_hold_reg;
        out_valid_next = out_valid_reg && !out_ready_i;
        ir_next        = ir_reg;
        xir_next       = xir_reg;
        xval_next      = xval_reg;
        pc_next        = pc_reg;
        pfx_err_next   = 1'b0;
`ifdef THOR2022_EXIM_EN
        mhold_next     = mhold_reg;
        mir_next       = mir_reg;
        mval_next      = mval_reg;
`endif
        if (flush_i) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
        end else if (accept) begin
            if (is_x) begin
                // A late X either replaces the held X or evicts a held M; both are ordering errors.
                xhold_next = in_ir_i;
                state_next = GX;
                if (state_reg == IDLE) pc_hold_next = in_pc_i;
                else                   pfx_err_next = 1'b1;
            end
`ifdef THOR2022_EXIM_EN
            else if (is_m) begin
                mhold_next = in_ir_i;
                case (state_reg)
                    IDLE: begin
                        pc_hold_next = in_pc_i;
                        state_next   = GM;
                    end
                    GX:      state_next   = GXM;
                    default: pfx_err_next = 1'b1;
                endcase
            end
`endif
            else begin
                out_valid_next = 1'b1;
                ir_next        = in_ir_i;
                xir_next       = x_held ? xhold_reg : '0;
                xval_next      = x_held;
                pc_next        = (state_reg == IDLE) ? in_pc_i : pc_hold_reg;
                state_next     = IDLE;
`ifdef THOR2022_EXIM_EN
                mir_next       = m_held ? mhold_reg : '0;
                mval_next      = m_held;
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            xhold_reg     <= '0;
            pc_hold_reg   <= '0;
            out_valid_reg <= 1'b0;
            ir_reg        <= '0;
            xir_reg       <= '0;
            xval_reg      <= 1'b0;
            pc_reg        <= '0;
            pfx_err_reg   <= 1'b0;
`ifdef THOR2022_EXIM_EN
            mhold_reg     <= '0;
            mir_reg       <= '0;
            mval_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            xhold_reg     <= xhold_next;
            pc_hold_reg   <= pc_hold_next;
            out_valid_reg <= out_valid_next;
            ir_reg        <= ir_next;
            xir_reg       <= xir_next;
            xval_reg      <= xval_next;
            pc_reg        <= pc_next;
            pfx_err_reg   <= pfx_err_next;
`ifdef THOR2022_EXIM_EN
            mhold_reg     <= mhold_next;
            mir_reg       <= mir_next;
            mval_reg      <= mval_next;
`endif
        end
    end

    assign out_valid_o = out_valid_reg;
    assign ir_o        = ir_reg;
    assign xir_o       = xir_reg;
    assign xval_o      = xval_reg;
    assign pc_o        = pc_reg;
    assign grp_open_o  = (state_reg != IDLE) && !m_held ? 1'b1 : (state_reg != IDLE);
    assign pfx_err_o   = pfx_err_reg;
`ifdef THOR2022_EXIM_EN
    assign mir_o       = mir_reg;
    assign mval_o      = mval_reg;
`else
    assign mir_o       = '0;
    assign mval_o      = 1'b0;
`endif

endmodule

// File: doc/thor2022_insn_gather.md
# thor2022_insn_gather

Groups the fetched instruction stream into decode packets for the Thor2022 decoder. Each packet is one base instruction plus any preceding EXI8/EXI24/EXI40/EXI56 (or +1 variant) prefix and EXIM prefix. The block sits between the fetch/align stage and the decoder. It drives the decoder's `ir`, `xir`, `xval`, `mir` and `mval` inputs with a registered valid/ready handshake, so a prefix group is never split across decode slots.

## Interface
Parameters:
- IW, 64, instruction word width; the opcode is bits [7:0].
- AW, 32, program-counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- flush_i  in  1  discard held prefixes and the output packet; has priority over all other inputs.
- in_valid_i  in  1  fetch word valid.
- in_ready_o  out  1  word accepted when in_valid_i && in_ready_o.
- in_ir_i  in  IW  instruction word.
- in_pc_i  in  AW  address of the word.
- out_valid_o  out  1  packet valid.
- out_ready_i  in  1  decoder accepts the packet.
- ir_o  out  IW  base instruction.
- xir_o  out  IW  EXI prefix word.
- xval_o  out  1  xir_o is meaningful.
- mir_o  out  IW  EXIM prefix word.
- mval_o  out  1  mir_o is meaningful.
- pc_o  out  AW  address of the first word of the group, used as the restart point.
- grp_open_o  out  1  a prefix is held; an interrupt must not be taken here.
- pfx_err_o  out  1  one-cycle pulse on a prefix-ordering violation.

## Operation
- A word is a prefix when its opcode is one of the package constants EXI8, EXI8+1, EXI24, EXI24+1, EXI40, EXI40+1, EXI56, EXI56+1 (X-prefix) or EXIM (M-prefix). Any other opcode is a base instruction.
- Gather state machine (held-prefix state):
  - IDLE.
  - GX: X held.
  - GM: M held.
  - GXM: both held.
- Transitions on each accepted word:
  - X-prefix: IDLE→GX. In GX, the new X replaces the held X and pfx_err pulses. In GM or GXM: pfx_err pulses, the held M is dropped, and the state becomes GX with the new X (X must precede M).
  - M-prefix: IDLE→GM, GX→GXM. In GM or GXM, the new M replaces the held M and pfx_err pulses.
  - Base instruction: load the output register with ir, the held xir/mir, xval = X held, mval = M held, and pc. Then return to IDLE.
- pc capture: the pc of the first prefix accepted in IDLE is latched. A base instruction accepted in IDLE uses its own pc. A replaced prefix does not update the latched pc.
- Unused xir_o/mir_o are driven 0 when xval_o/mval_o is 0.
- grp_open_o = (state != IDLE).
- flush_i: state→IDLE, out_valid_o→0, and the same-cycle input word is discarded. in_ready_o is still driven per the rule below, but the word is dropped.

## Timing
- Output stage is a single register: in_ready_o = !out_valid_o || out_ready_i. Prefix words are also gated by in_ready_o, so stalls are uniform.
- Latency: a base word accepted at cycle N gives out_valid_o=1 at N+1.
- Back-to-back base instructions sustain one packet per cycle when out_ready_i=1.
- Simultaneous output handshake and base-word acceptance in one cycle: the new packet replaces the old one and out_valid_o stays 1.
- out_valid_o=1 && !out_ready_i: all outputs hold stable.
- Reset values: state IDLE, out_valid_o=0, ir_o/xir_o/mir_o=0, xval_o=0, mval_o=0, pc_o=0, grp_open_o=0, pfx_err_o=0. in_ready_o=1 in the first cycle after reset.
- Reset or flush mid-group loses the held prefixes. Fetch must refetch from pc_o.

## Configuration
- THOR2022_EXIM_EN defined: M-prefix handling is as above.
- THOR2022_EXIM_EN undefined:
  - EXIM is treated as a base instruction and forwarded in ir_o.
  - GM/GXM states are removed.
  - mval_o is tied 0 and mir_o is tied 0.

## Test plan
- Reset, then ADDI word at pc 0x100 with out_ready_i=1 -> next cycle out_valid_o=1, ir_o=word, xval_o=0, mval_o=0, pc_o=0x100.
- EXI24 @0x200, EXIM @0x208, LDO @0x210 -> a single packet with xval_o=1, mval_o=1, pc_o=0x200. grp_open_o=1 for the two cycles after each prefix is accepted.
- EXI8, EXI40, ADDIL -> pfx_err_o pulses once and the packet has xir_o=EXI40 word; then EXIM, EXI8, ADD -> pfx_err_o pulses, mval_o=0, xir_o=EXI8 word.
- Packet held with out_ready_i=0 for 3 cycles -> in_ready_o=0 and the outputs stay stable; out_ready_i=1 with a new base word in the same cycle -> the next packet appears with no bubble.
- EXI56 accepted, then flush_i=1 -> grp_open_o=0; the next base word produces xval_o=0. Repeating with rst_ni=0 instead gives all outputs at their reset values.
- With THOR2022_EXIM_EN undefined, EXIM word then ADD -> two packets; the first has ir_o=EXIM word; mval_o=0 throughout.
